// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if
//   Bundles the burst reader's control, RAM-side and consumer-side signals.
//   master : the burst reader (drives RAM address, output word port, status)
//   slave  : the surrounding system (issues requests, supplies RAM_Q, OUT_READY)
//   Signals:
//     START/START_ADDR/LEN/ABORT  burst request and abort
//     RAM_ADDR/RAM_WREN/RAM_Q     RAM read port (write enable always 0)
//     OUT_DATA/OUT_ADDR/OUT_VALID/OUT_READY  word output, valid/ready handshake
//     BUSY/DONE                   status
interface ram_burst_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int LEN_W  = 6
);
    logic              START;
    logic [ADDR_W-1:0] START_ADDR;
    logic [LEN_W-1:0]  LEN;
    logic              ABORT;

    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_WREN;
    logic [DATA_W-1:0] RAM_Q;

    logic [DATA_W-1:0] OUT_DATA;
    logic [ADDR_W-1:0] OUT_ADDR;
    logic              OUT_VALID;
    logic              OUT_READY;

    logic              BUSY;
    logic              DONE;

    modport master (
        input  START, START_ADDR, LEN, ABORT, RAM_Q, OUT_READY,
        output RAM_ADDR, RAM_WREN, OUT_DATA, OUT_ADDR, OUT_VALID, BUSY, DONE
    );

    modport slave (
        output START, START_ADDR, LEN, ABORT, RAM_Q, OUT_READY,
        input  RAM_ADDR, RAM_WREN, OUT_DATA, OUT_ADDR, OUT_VALID, BUSY, DONE
    );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Reads LEN consecutive words (wrapping modulo 2^ADDR_W) from a RAM with a
//   registered address and presents each word with its address on a
//   valid/ready port. DONE pulses one cycle after the last word is accepted.
//   Ports:
//     CLK    rising-edge clock
//     RST_N  asynchronous active-low reset
//     bus    ram_burst_reader_if.master (request, RAM port, output port, status)
module ram_burst_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int LEN_W  = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    ram_burst_reader_if.master    bus
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  len_clamped;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            ram_addr_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            ram_addr_q  <= ram_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ram_addr_d  = ram_addr_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        len_clamped = (bus.LEN > DEPTH) ? DEPTH : bus.LEN;

        if (bus.ABORT) begin
            // ABORT in IDLE (even alongside START) leaves everything untouched.
            if (state_q != S_IDLE) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        addr_d = bus.START_ADDR;
                        rem_d  = len_clamped;
                        if (len_clamped == '0) begin
                            done_d = 1'b1;
                        end else begin
                            // Address goes out together with the move into ISSUE
                            // so the RAM registers it at the following edge.
                            ram_addr_d = bus.START_ADDR;
                            state_d    = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    out_data_d  = bus.RAM_Q;
                    out_addr_d  = addr_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
                S_HOLD: begin
                    if (bus.OUT_READY) begin
                        out_valid_d = 1'b0;
                        rem_d       = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d     = addr_q + ADDR_W'(1);
                            ram_addr_d = addr_q + ADDR_W'(1);
                            state_d    = S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.RAM_ADDR  = ram_addr_q;
    assign bus.RAM_WREN  = 1'b0;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_ADDR  = out_addr_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BUSY      = (state_q != S_IDLE);
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;
    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int LW    = 6;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ram_burst_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    ram_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM: address registered on the clock, data follows the registered address
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_areg = '0;
    always @(posedge clk) ram_areg <= bus.RAM_ADDR;
    assign bus.RAM_Q = mem[ram_areg];

    // Observation of handshakes and status at each rising edge
    int cyc        = 0;
    int done_total = 0;
    int busy_seen  = 0;
    int hs_addr[$];
    int hs_data[$];
    int hs_cyc[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
            hs_addr.push_back(int'(bus.OUT_ADDR));
            hs_data.push_back(int'(bus.OUT_DATA));
            hs_cyc.push_back(cyc);
        end
        if (bus.DONE === 1'b1) done_total = done_total + 1;
        if (bus.BUSY === 1'b1) busy_seen = busy_seen + 1;
    end

    int total    = 0;
    int bad      = 0;
    int exp_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        hs_addr.delete();
        hs_data.delete();
        hs_cyc.delete();
        busy_seen = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ram_addr"},  bus.RAM_ADDR,  0);
        chk({tag, "_out_data"},  bus.OUT_DATA,  0);
        chk({tag, "_out_addr"},  bus.OUT_ADDR,  0);
        chk({tag, "_out_valid"}, bus.OUT_VALID, 0);
        chk({tag, "_busy"},      bus.BUSY,      0);
        chk({tag, "_done"},      bus.DONE,      0);
        chk({tag, "_wren"},      bus.RAM_WREN,  0);
    endtask

    // Drive a one-cycle START; s is the edge number that samples it
    task automatic start_burst(input int sa, input int len, output int s);
        bus.START_ADDR = sa[AW-1:0];
        bus.LEN        = len[LW-1:0];
        bus.START      = 1'b1;
        s = cyc + 1;
        step();
        bus.START = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 5 cycles on the 2nd word
    // Returns with DONE visible; d is the edge after which DONE rose (-1 on timeout)
    task automatic wait_burst(input int sa, input int s, input int mode, input bit inject,
                              input int budget, output int d);
        int w;
        d = -1;
        w = (sa + 1) % DEPTH;
        for (int k = 0; k < budget; k++) begin
            if (bus.DONE === 1'b1) begin
                d = cyc;
                break;
            end
            if (mode == 2 && cyc >= s + 5 && cyc <= s + 10) begin
                chk("stall_valid", bus.OUT_VALID, 1);
                chk("stall_addr",  bus.OUT_ADDR,  w);
                chk("stall_data",  bus.OUT_DATA,  int'(mem[w]));
            end
            if (inject && cyc == s + 4) begin
                bus.START      = 1'b1;
                bus.START_ADDR = 5'd20;
                bus.LEN        = 6'd5;
            end else begin
                bus.START = 1'b0;
            end
            case (mode)
                1:       bus.OUT_READY = 1'($urandom_range(0, 1));
                2:       bus.OUT_READY = (cyc + 1 >= s + 6 && cyc + 1 <= s + 10) ? 1'b0 : 1'b1;
                default: bus.OUT_READY = 1'b1;
            endcase
            step();
        end
        bus.START     = 1'b0;
        bus.OUT_READY = 1'b1;
    endtask

    // Reference: n = min(len, 32) words at (sa+i) mod 32; with ready high word i
    // is accepted at edge s+3+3i (+5 from the 2nd word on when stalled)
    task automatic check_burst(input string tag, input int sa, input int len, input int s,
                               input int d, input bit timed, input bit stall);
        int n;
        int a;
        int exp_hs;
        int exp_d;
        n = (len > DEPTH) ? DEPTH : len;
        chk({tag, "_count"}, hs_addr.size(), n);
        exp_d = s;
        for (int i = 0; i < n && i < hs_addr.size(); i++) begin
            a = (sa + i) % DEPTH;
            chk({tag, "_addr"}, hs_addr[i], a);
            chk({tag, "_data"}, hs_data[i], int'(mem[a]));
            exp_hs = s + 3 + 3 * i + ((stall && i >= 1) ? 5 : 0);
            if (timed) chk({tag, "_hs_edge"}, hs_cyc[i], exp_hs);
            exp_d = timed ? exp_hs : hs_cyc[i];
        end
        chk({tag, "_done_edge"}, d, exp_d);
        chk({tag, "_busy_in_done"}, bus.BUSY, 0);
        exp_done++;
    endtask

    initial begin
        int s;
        int d;
        int sa;
        int ln;
        logic [AW-1:0] ra_before;

        bus.START      = 1'b0;
        bus.START_ADDR = '0;
        bus.LEN        = '0;
        bus.ABORT      = 1'b0;
        bus.OUT_READY  = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i % 16);

        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2 chk_reset("por");
        step();
        step();
        rst_n = 1'b1;
        step();

        // basic burst with latency checks
        clear_obs();
        start_burst(3, 4, s);
        chk("busy_rise", bus.BUSY, 1);
        chk("ram_addr_issue", bus.RAM_ADDR, 3);
        chk("valid_s0", bus.OUT_VALID, 0);
        step();
        chk("valid_s1", bus.OUT_VALID, 0);
        step();
        chk("valid_s2", bus.OUT_VALID, 1);
        wait_burst(3, s, 0, 0, 200, d);
        check_burst("b1", 3, 4, s, d, 1, 0);

        // wrap, then a clamped full sweep started in the DONE cycle
        clear_obs();
        start_burst(30, 4, s);
        wait_burst(30, s, 0, 0, 200, d);
        check_burst("wrap", 30, 4, s, d, 1, 0);
        clear_obs();
        start_burst(0, 40, s);
        wait_burst(0, s, 0, 0, 400, d);
        check_burst("full", 0, 40, s, d, 1, 0);
        step();
        step();
        chk("done_total_a", done_total, exp_done);

        // backpressure on the second word
        clear_obs();
        start_burst(7, 4, s);
        wait_burst(7, s, 2, 0, 200, d);
        check_burst("stall", 7, 4, s, d, 1, 1);
        step();

        // LEN=0: DONE next cycle, no BUSY, RAM address untouched
        ra_before = bus.RAM_ADDR;
        clear_obs();
        start_burst(9, 0, s);
        chk("len0_busy", bus.BUSY, 0);
        chk("len0_ram_addr", bus.RAM_ADDR, ra_before);
        wait_burst(9, s, 0, 0, 10, d);
        check_burst("len0", 9, 0, s, d, 1, 0);
        step();
        chk("len0_done_low", bus.DONE, 0);
        step();
        chk("len0_busy_seen", busy_seen, 0);

        // START while busy is ignored
        clear_obs();
        start_burst(12, 3, s);
        wait_burst(12, s, 0, 1, 200, d);
        check_burst("ign_start", 12, 3, s, d, 1, 0);
        step();
        step();
        chk("ign_no_extra", hs_addr.size(), 3);
        chk("done_total_b", done_total, exp_done);

        // ABORT with START in IDLE: nothing happens
        ra_before = bus.RAM_ADDR;
        bus.START_ADDR = 5'd17;
        bus.LEN        = 6'd3;
        bus.START      = 1'b1;
        bus.ABORT      = 1'b1;
        step();
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        chk("idle_abort_busy", bus.BUSY, 0);
        chk("idle_abort_ram_addr", bus.RAM_ADDR, ra_before);
        step();
        chk("idle_abort_done", bus.DONE, 0);

        // ABORT in HOLD of the 2nd word
        clear_obs();
        start_burst(2, 8, s);
        for (int k = 0; k < 20 && cyc < s + 5; k++) step();
        chk("abort_pre_valid", bus.OUT_VALID, 1);
        bus.OUT_READY = 1'b0;
        bus.ABORT     = 1'b1;
        step();
        bus.ABORT     = 1'b0;
        bus.OUT_READY = 1'b1;
        chk("abort_valid", bus.OUT_VALID, 0);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_done", bus.DONE, 0);
        chk("abort_out_addr", bus.OUT_ADDR, 3);
        chk("abort_out_data", bus.OUT_DATA, int'(mem[3]));
        step();
        step();
        chk("abort_hs", hs_addr.size(), 1);
        chk("done_total_c", done_total, exp_done);
        clear_obs();
        start_burst(10, 1, s);
        wait_burst(10, s, 0, 0, 50, d);
        check_burst("post_abort", 10, 1, s, d, 1, 0);
        step();

        // asynchronous reset in WAIT
        clear_obs();
        start_burst(4, 3, s);
        step();
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_wait");
        step();
        #2 rst_n = 1'b1;
        step();
        clear_obs();
        start_burst(5, 2, s);
        wait_burst(5, s, 0, 0, 50, d);
        check_burst("post_rst", 5, 2, s, d, 1, 0);
        step();

        // random contents, start address, length and backpressure
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int r = 0; r < 6; r++) begin
            sa = int'($urandom_range(0, DEPTH - 1));
            ln = int'($urandom_range(0, 40));
            clear_obs();
            start_burst(sa, ln, s);
            wait_burst(sa, s, 1, 0, 3000, d);
            check_burst("rnd", sa, ln, s, d, 0, 0);
            step();
        end
        step();
        chk("done_total_end", done_total, exp_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side companion to the 32x4 LPM RAM (5-bit address, 4-bit data, address registered on CLK, q valid one cycle later). On a START pulse it reads LEN consecutive words beginning at START_ADDR, wrapping modulo 32. Each word is presented with its address on a valid/ready output port, and DONE pulses when the burst completes. It sits between the RAM and a display/UART consumer and owns the RAM address bus while busy. Its write enable is tied low.

## Interface
- ADDR_W, 5: RAM address width; depth is 2^ADDR_W.
- DATA_W, 4: RAM data width.
- LEN_W, 6: burst length field width (must hold 2^ADDR_W).

- CLK  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  burst request; sampled only in IDLE.
- START_ADDR  in  ADDR_W  first address of burst; sampled with START.
- LEN  in  LEN_W  words to read; sampled with START.
- ABORT  in  1  synchronous abort; highest priority after reset.
- RAM_ADDR  out  ADDR_W  registered address to RAM.
- RAM_WREN  out  1  constant 0.
- RAM_Q  in  DATA_W  RAM read data.
- OUT_DATA  out  DATA_W  captured word.
- OUT_ADDR  out  ADDR_W  address OUT_DATA was read from.
- OUT_VALID  out  1  OUT_DATA/OUT_ADDR valid.
- OUT_READY  in  1  consumer accepts when OUT_VALID & OUT_READY at a rising edge.
- BUSY  out  1  high in any state but IDLE.
- DONE  out  1  one-cycle pulse after last word accepted.

## Operation
- Reset values, applied asynchronously while RST_N=0:
  - state IDLE, RAM_ADDR=0, OUT_DATA=0, OUT_ADDR=0, OUT_VALID=0, BUSY=0, DONE=0, internal remaining count=0.
- States:
  - IDLE: on START, latch addr=START_ADDR and remaining=min(LEN, 2^ADDR_W).
    - If remaining=0, pulse DONE next cycle and stay IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: RAM_ADDR=addr. Go to WAIT.
  - WAIT: RAM_Q now reflects addr. At edge, OUT_DATA<=RAM_Q, OUT_ADDR<=addr, OUT_VALID<=1. Go to HOLD.
  - HOLD: hold OUT_* stable until handshake.
    - On handshake: OUT_VALID<=0 and remaining<=remaining-1.
    - If remaining was 1: DONE<=1 for one cycle and go to IDLE.
    - Otherwise addr<=addr+1 mod 2^ADDR_W and go to ISSUE.
- Length rules:
  - LEN values above 2^ADDR_W are clamped; no address is read twice per burst.
  - LEN=32 from any START_ADDR reads every location exactly once.
- START is ignored while BUSY.
  - START coinciding with the DONE cycle is accepted, since the FSM is in IDLE that cycle.
- ABORT in any non-IDLE state: next edge goes to IDLE with OUT_VALID=0, BUSY=0, and no DONE.
  - OUT_DATA/OUT_ADDR keep their last values.
  - ABORT in IDLE is a no-op. ABORT and START together in IDLE: ABORT wins, START is dropped.
- Reset mid-burst: immediate return to reset values. Any partially presented word is discarded.
- OUT_READY is ignored when OUT_VALID=0.

## Timing
- Edge numbering: START sampled at edge 0.
  - RAM_ADDR valid after edge 0 (ISSUE). RAM latches it at edge 1.
  - OUT_VALID rises after edge 2.
- First-word latency: 2 cycles from START edge to OUT_VALID.
- Throughput with OUT_READY held high: one word per 3 cycles (ISSUE, WAIT, HOLD).
- DONE is asserted in the cycle after the final handshake edge, with BUSY=0 that cycle.
- BUSY rises the cycle after START is accepted.
  - For LEN=0, BUSY stays 0 and DONE pulses once.
- All outputs are registered; no combinational path from OUT_READY or RAM_Q to any output.

## Test plan
- Preload RAM[i]=i mod 16. START_ADDR=3, LEN=4, OUT_READY=1 -> (addr,data) = (3,3),(4,4),(5,5),(6,6). First OUT_VALID 2 cycles after START, words every 3 cycles, one DONE pulse.
- Wrap: START_ADDR=30, LEN=4 -> addresses 30,31,0,1. Then START_ADDR=0, LEN=40 -> exactly 32 words, addresses 0..31, one DONE.
- Backpressure: OUT_READY=0 for 5 cycles on the second word -> OUT_DATA/OUT_ADDR stable and OUT_VALID high throughout. No skipped or duplicated word; total cycle count +5.
- LEN=0 -> no RAM_ADDR change, BUSY never 1, DONE pulses exactly one cycle later. START asserted during BUSY -> ignored, and the burst sequence is unchanged.
- ABORT asserted in HOLD of the 2nd word of LEN=8 -> next cycle OUT_VALID=0, BUSY=0, and no DONE. A following START_ADDR=10, LEN=1 runs normally.
- RST_N pulled low asynchronously mid-WAIT -> all outputs reach reset values without a clock edge. After release, a START_ADDR=5, LEN=2 burst returns (5,5),(6,6).
